// File: rtl/fcmp_pred.sv
// fcmp_pred: floating-point compare predicate stage.
//
// Turns the flags from a compare unit into the FEQ, FLT or FLE predicate and its
// invalid-operation flag. The result sits in a one-entry output register with a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid, in_ready    input handshake (in_ready = !out_valid | out_ready)
//   op                    00 FEQ, 01 FLT, 10 FLE, 11 reserved (result 0, nv 1)
//   altb, blta, aeqb      compare flags: A>B, B>A, A=B
//   unordered, snan       either operand NaN / either operand signaling NaN
//   out_valid, out_ready  output handshake
//   result, nv            registered predicate and invalid flag
//   nv_sticky             accumulated invalid flag
//   err_sticky            accumulated flag-consistency error (ordered, flags not one-hot)
//   clr_flags             clears both sticky flags; a same-cycle set wins
//   unord_cnt             saturating count of unordered compares
//
// Build option: define FCMP_PRED_UNORD_CNT_EN to enable the unordered counter.
// Without it, unord_cnt is tied to zero and there is no counter register.
module fcmp_pred (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic        altb,
  input  logic        blta,
  input  logic        aeqb,
  input  logic        unordered,
  input  logic        snan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        result,
  output logic        nv,
  output logic        nv_sticky,
  output logic        err_sticky,
  input  logic        clr_flags,
  output logic [15:0] unord_cnt
);

  localparam logic [1:0] OpFeq = 2'b00;
  localparam logic [1:0] OpFlt = 2'b01;
  localparam logic [1:0] OpFle = 2'b10;

  logic out_valid_q;
  logic result_q;
  logic nv_q;
  logic nv_sticky_q;
  logic err_sticky_q;

  logic fire;
  logic pred_result;
  logic pred_nv;
  logic flags_onehot;
  logic flag_err;

  assign in_ready = !out_valid_q | out_ready;
  assign fire     = in_valid & in_ready;

  always_comb begin
    pred_result = 1'b0;
    pred_nv     = 1'b1;
    case (op)
      OpFeq: begin
        pred_result = aeqb & !unordered;
        pred_nv     = snan;
      end
      OpFlt: begin
        pred_result = blta & !unordered;
        pred_nv     = unordered;
      end
      OpFle: begin
        pred_result = (blta | aeqb) & !unordered;
        pred_nv     = unordered;
      end
      default: begin
        pred_result = 1'b0;
        pred_nv     = 1'b1;
      end
    endcase
  end

  // Exactly one of the three flags set: odd parity, and not all three set.
  assign flags_onehot = (altb ^ blta ^ aeqb) & !(altb & blta & aeqb);
  assign flag_err     = fire & !unordered & !flags_onehot;

  // Output register. A drain in the same cycle as a fire reloads it and keeps
  // out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= 1'b0;
      nv_q        <= 1'b0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      result_q    <= pred_result;
      nv_q        <= pred_nv;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Sticky flags: a set takes priority over clr_flags in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nv_sticky_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      if (fire && pred_nv) begin
        nv_sticky_q <= 1'b1;
      end else if (clr_flags) begin
        nv_sticky_q <= 1'b0;
      end
      if (flag_err) begin
        err_sticky_q <= 1'b1;
      end else if (clr_flags) begin
        err_sticky_q <= 1'b0;
      end
    end
  end

`ifdef FCMP_PRED_UNORD_CNT_EN
  logic [15:0] unord_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unord_cnt_q <= 16'h0000;
    end else if (fire && unordered && (unord_cnt_q != 16'hFFFF)) begin
      unord_cnt_q <= unord_cnt_q + 16'h0001;
    end
  end

  assign unord_cnt = unord_cnt_q;
`else
  assign unord_cnt = 16'h0000;
`endif

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign nv         = nv_q;
  assign nv_sticky  = nv_sticky_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_fcmp_pred.sv
// Self-checking bench for fcmp_pred: directed covers plus randomized traffic,
// compared against a behavioural model of the predicate rules and handshake.
module tb_fcmp_pred;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic        altb;
  logic        blta;
  logic        aeqb;
  logic        unordered;
  logic        snan;
  logic        out_valid;
  logic        out_ready;
  logic        result;
  logic        nv;
  logic        nv_sticky;
  logic        err_sticky;
  logic        clr_flags;
  logic [15:0] unord_cnt;

  int checks;
  int errors;

  // Reference state.
  logic        m_valid;
  logic        m_result;
  logic        m_nv;
  logic        m_nvs;
  logic        m_err;
  int unsigned m_cnt;

  fcmp_pred dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .altb       (altb),
    .blta       (blta),
    .aeqb       (aeqb),
    .unordered  (unordered),
    .snan       (snan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .nv         (nv),
    .nv_sticky  (nv_sticky),
    .err_sticky (err_sticky),
    .clr_flags  (clr_flags),
    .unord_cnt  (unord_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Predicate rules: returns {result, nv}.
  function automatic logic [1:0] ref_pred(input logic [1:0] o, input logic gt_b, input logic lt_b,
                                          input logic eq, input logic u, input logic s);
    bit r;
    bit n;
    if (o == 2'd0)      begin r = eq && !u;          n = s; end
    else if (o == 2'd1) begin r = lt_b && !u;        n = u; end
    else if (o == 2'd2) begin r = (lt_b || eq) && !u; n = u; end
    else                begin r = 0;                 n = 1; end
    if (gt_b) r = r; // A>B never makes any supported predicate true
    return {r, n};
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef FCMP_PRED_UNORD_CNT_EN
    return m_cnt[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, m_valid});
    check({tag, ".result"}, {15'd0, result}, {15'd0, m_result});
    check({tag, ".nv"}, {15'd0, nv}, {15'd0, m_nv});
    check({tag, ".nv_sticky"}, {15'd0, nv_sticky}, {15'd0, m_nvs});
    check({tag, ".err_sticky"}, {15'd0, err_sticky}, {15'd0, m_err});
    check({tag, ".unord_cnt"}, unord_cnt, exp_cnt());
  endtask

  // One clock cycle; entered and left just after a falling edge.
  task automatic step(input string tag, input logic iv, input logic [1:0] o, input logic a,
                      input logic b, input logic e, input logic u, input logic s,
                      input logic ordy, input logic clr, input bit full);
    logic       fire;
    logic [1:0] p;
    int         ones;
    in_valid = iv; op = o; altb = a; blta = b; aeqb = e; unordered = u; snan = s;
    out_ready = ordy; clr_flags = clr;
    #1;
    check({tag, ".in_ready"}, {15'd0, in_ready}, {15'd0, (!m_valid || ordy)});
    fire = iv && (!m_valid || ordy);
    p    = ref_pred(o, a, b, e, u, s);
    ones = int'(a) + int'(b) + int'(e);
    @(posedge clk);
    if (fire) begin
      m_valid = 1; m_result = p[1]; m_nv = p[0];
    end else if (ordy) begin
      m_valid = 0;
    end
    if (fire && p[0]) m_nvs = 1;
    else if (clr) m_nvs = 0;
    if (fire && !u && ones != 1) m_err = 1;
    else if (clr) m_err = 0;
    if (fire && u && m_cnt < 32'hFFFF) m_cnt++;
    @(negedge clk);
    if (full) check_outputs(tag);
  endtask

  task automatic model_reset();
    m_valid = 0; m_result = 0; m_nv = 0; m_nvs = 0; m_err = 0; m_cnt = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst_n = 0; in_valid = 0; op = 0; altb = 0; blta = 0; aeqb = 0;
    unordered = 0; snan = 0; out_ready = 0; clr_flags = 0;
    #2;
    check_outputs("reset");
    check("reset.in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // FLT with B>A, ordered.
    step("flt", 1, 2'b01, 0, 1, 0, 0, 0, 1, 0, 1);
    // FEQ unordered quiet NaN: no nv; then signaling NaN sets nv and sticky.
    step("feq_qnan", 1, 2'b00, 0, 0, 0, 1, 0, 1, 0, 1);
    step("feq_snan", 1, 2'b00, 0, 0, 0, 1, 1, 1, 0, 1);
    step("drain", 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 1);

    // Backpressure: hold for 3 cycles, then drain and fire together.
    step("hold_load", 1, 2'b10, 0, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("hold", 1, 2'b01, 0, 1, 0, 0, 0, 0, 0, 1);
    step("drain_fire", 1, 2'b01, 0, 1, 0, 0, 0, 1, 0, 1);
    step("drain2", 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1);

    // clr_flags with a same-cycle invalid fire: set wins.
    step("clr_vs_set", 1, 2'b10, 0, 0, 0, 1, 0, 1, 1, 1);
    // Flag inconsistency then clear alone.
    step("err_set", 1, 2'b00, 1, 1, 1, 0, 0, 1, 0, 1);
    step("err_clr", 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 1);
    // Reserved op.
    step("op11", 1, 2'b11, 0, 0, 1, 0, 0, 1, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0), 1);
    end

`ifdef FCMP_PRED_UNORD_CNT_EN
    // Drive the counter up to 16'hFFFE, then three more unordered fires saturate it.
    while (m_cnt < 32'hFFFE) step("fill", 1, 2'b01, 0, 0, 0, 1, 0, 1, 0, 0);
    check("cnt_preload", unord_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) step("sat", 1, 2'b01, 0, 0, 0, 1, 0, 1, 0, 1);
    check("cnt_sat", unord_cnt, 16'hFFFF);
    step("cnt_clr", 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 1);
`endif

    // Asynchronous reset with a pending result, no clock edge.
    step("pend", 1, 2'b01, 0, 0, 0, 1, 1, 0, 0, 1);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    check("rst_hold.in_ready", {15'd0, in_ready}, 16'd1);
    check_outputs("rst_hold");
    rst_n = 1;
    step("post_rst", 1, 2'b00, 0, 0, 1, 0, 0, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fcmp_pred.md
FCMP_PRED -- requirements
Module: fcmp_pred

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: compare result and op on inputs are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: stage accepts input this cycle.
REQ-005 SHALL have port op, input, 2 bits: predicate select; 00 FEQ, 01 FLT, 10 FLE, 11 reserved.
REQ-006 SHALL have port altb, input, 1 bit: compare-unit flag for A>B.
REQ-007 SHALL have port blta, input, 1 bit: compare-unit flag for B>A.
REQ-008 SHALL have port aeqb, input, 1 bit: compare-unit flag for A=B.
REQ-009 SHALL have port unordered, input, 1 bit: either operand is NaN.
REQ-010 SHALL have port snan, input, 1 bit: either operand is a signaling NaN, from the operand classifier.
REQ-011 SHALL have port out_valid, output, 1 bit: result register holds an undelivered result.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port result, output, 1 bit: predicate value.
REQ-014 SHALL have port nv, output, 1 bit: invalid-operation flag for this result.
REQ-015 SHALL have port nv_sticky, output, 1 bit: accumulated invalid flag.
REQ-016 SHALL have port err_sticky, output, 1 bit: accumulated flag-consistency error.
REQ-017 SHALL have port clr_flags, input, 1 bit: clears the sticky flags.
REQ-018 SHALL have port unord_cnt, output, 16 bits: count of unordered compares.

Function
REQ-019 SHALL drive in_ready = !out_valid | out_ready, combinationally.
REQ-020 SHALL accept (fire) when in_valid & in_ready; latency fire to out_valid is 1 cycle.
REQ-021 SHALL, on fire, register the result and nv and set out_valid = 1.
REQ-022 SHALL clear out_valid when out_valid & out_ready & !fire; on simultaneous drain and fire it SHALL load the new result and hold out_valid = 1.
REQ-023 SHALL hold result and nv stable while out_valid & !out_ready.
REQ-024 SHALL compute result, with altb = A>B and blta = B>A:
- FEQ = aeqb & !unordered
- FLT = blta & !unordered
- FLE = (blta | aeqb) & !unordered
- op 11 = 0
REQ-025 SHALL compute nv:
- FEQ: snan
- FLT, FLE: unordered
- op 11: 1
REQ-026 SHALL set nv_sticky the cycle after a fire with nv = 1.
REQ-027 SHALL clear nv_sticky on clr_flags; if a fire with nv = 1 occurs in the same cycle, set wins.
REQ-028 SHALL set err_sticky on a fire with unordered = 0 and {altb, blta, aeqb} not one-hot; clr_flags clears it, and set wins over clear.
REQ-029 SHALL compute err_sticky independently of the result; result still follows REQ-024.
REQ-030 SHALL leave clr_flags without effect on out_valid, result, nv and unord_cnt.

Reset
REQ-031 SHALL, while rst_n = 0, immediately force out_valid = 0, result = 0, nv = 0, nv_sticky = 0, err_sticky = 0 and unord_cnt = 0.
REQ-032 SHALL, when reset asserts while a result is pending, discard that result; in_ready = 1 holds throughout reset.

Configuration
REQ-033 SHALL, with macro FCMP_PRED_UNORD_CNT_EN defined, increment unord_cnt by 1 on each fire with unordered = 1, saturating at 16'hFFFF, not wrapping, and not cleared by clr_flags.
REQ-034 SHALL, without FCMP_PRED_UNORD_CNT_EN, tie unord_cnt to 16'h0000 and contain no counter register.

Verification
REQ-035 SHALL cover: op=01, blta=1, unordered=0, out_ready=1 -> next cycle out_valid=1, result=1, nv=0.
REQ-036 SHALL cover: op=00, unordered=1, snan=0 -> result=0, nv=0, nv_sticky unchanged; repeat with snan=1 -> nv=1, nv_sticky=1.
REQ-037 SHALL cover: out_ready=0 with a result held for 3 cycles -> in_ready=0, result stable; then out_ready=1 with in_valid=1 -> new result loaded the same cycle, out_valid stays 1.
REQ-038 SHALL cover: clr_flags=1 in the same cycle as a fire with op=10, unordered=1 -> nv_sticky=1 afterwards.
REQ-039 SHALL cover: fire with unordered=0 and altb=blta=aeqb=1 -> err_sticky=1; then clr_flags alone -> err_sticky=0.
REQ-040 SHALL cover: with FCMP_PRED_UNORD_CNT_EN, preload to 16'hFFFE, then 3 unordered fires -> 16'hFFFF; rst_n=0 mid-stream -> unord_cnt=0 and out_valid=0 with no clock edge.
